// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Host-side initiator for the 4-bit ALU tile. Commands arrive on a
// valid/ready stream, go out to the ALU through registered operand and
// opcode outputs, and the ALU result is captured a fixed number of edges
// later. Results come back in order through a response FIFO. Commands are
// only accepted while (buffered + in-flight) responses leave room in the FIFO.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_op, cmd_a, cmd_b        opcode and operands
//   cmd_tag                     opaque tag echoed with the response
//   alu_ab, alu_op              registered {a,b} and opcode to the ALU
//   alu_result/carry/ovf        ALU outputs
//   rsp_valid/rsp_ready         response handshake
//   rsp_result/carry/ovf/err    response payload from the FIFO head
//   rsp_tag                     tag of the head response
//   busy                        any command in flight or buffered
//   issue_count                 accepted commands, wraps at 16 bits
module alu_cmd_sequencer #(
  parameter int unsigned ALU_LAT   = 1,
  parameter int unsigned RSP_DEPTH = 4,
  parameter int unsigned TAG_W     = 4,
  parameter logic [3:0]  IDLE_OP   = 4'b1111
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [7:0]       alu_ab,
  output logic [3:0]       alu_op,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry,
  input  logic             alu_ovf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_err,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy,
  output logic [15:0]      issue_count
);

  localparam int unsigned PIPE_LEN = ALU_LAT + 1;
  localparam int unsigned TAIL     = PIPE_LEN - 1;
  localparam int unsigned PTR_W    = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam int unsigned RSP_W    = TAG_W + 11;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(RSP_DEPTH);
  localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(RSP_DEPTH);

  logic                accept;
  logic                op_illegal;
  logic                op_addsub;
  logic [PIPE_LEN-1:0] pipe_vld;
  logic [PIPE_LEN-1:0] pipe_addsub;
  logic [PIPE_LEN-1:0] pipe_err;
  logic [TAG_W-1:0]    pipe_tag [PIPE_LEN];
  logic [CNT_W-1:0]    inflight;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      occupancy;
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [RSP_W-1:0]    mem [RSP_DEPTH];
  logic [RSP_W-1:0]    push_word;
  logic [RSP_W-1:0]    head_word;
  logic                push;
  logic                pop;

  assign op_illegal = (cmd_op > 4'hA);
  assign op_addsub  = (cmd_op == 4'h0) || (cmd_op == 4'h1);

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PIPE_LEN; i++) begin
      inflight = inflight + CNT_W'(pipe_vld[i]);
    end
  end

  // Credit is derived from registered state only, so cmd_ready never
  // depends on cmd_valid.
  assign occupancy = {1'b0, fifo_count} + {1'b0, inflight};
  assign cmd_ready = (occupancy < CREDIT_LIM);
  assign accept    = cmd_valid && cmd_ready;

  assign push = pipe_vld[TAIL];
  assign pop  = rsp_valid && rsp_ready;

  // Flags are only meaningful for ADD/SUB; the ALU holds them across other
  // ops, so they are masked here. Illegal ops never reached the ALU.
  assign push_word = {pipe_tag[TAIL],
                      pipe_err[TAIL],
                      pipe_err[TAIL] ? 8'h00 : alu_result,
                      pipe_addsub[TAIL] & alu_carry,
                      pipe_addsub[TAIL] & alu_ovf};

  assign rsp_valid = (fifo_count != '0);
  assign head_word = rsp_valid ? mem[rd_ptr] : '0;
  assign {rsp_tag, rsp_err, rsp_result, rsp_carry, rsp_ovf} = head_word;

  assign busy = (|pipe_vld) || (fifo_count != '0);

  // ALU drive and capture pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_ab      <= '0;
      alu_op      <= IDLE_OP;
      pipe_vld    <= '0;
      pipe_addsub <= '0;
      pipe_err    <= '0;
      for (int unsigned i = 0; i < PIPE_LEN; i++) begin
        pipe_tag[i] <= '0;
      end
      issue_count <= '0;
    end else begin
      if (accept && !op_illegal) begin
        alu_ab <= {cmd_a, cmd_b};
        alu_op <= cmd_op;
      end else begin
        alu_ab <= '0;
        alu_op <= IDLE_OP;
      end
      pipe_vld[0]    <= accept;
      pipe_addsub[0] <= accept && op_addsub;
      pipe_err[0]    <= accept && op_illegal;
      pipe_tag[0]    <= cmd_tag;
      for (int unsigned i = 1; i < PIPE_LEN; i++) begin
        pipe_vld[i]    <= pipe_vld[i-1];
        pipe_addsub[i] <= pipe_addsub[i-1];
        pipe_err[i]    <= pipe_err[i-1];
        pipe_tag[i]    <= pipe_tag[i-1];
      end
      if (accept) begin
        issue_count <= issue_count + 16'd1;
      end
    end
  end

  // Response FIFO control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Storage needs no reset: outputs are gated by rsp_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_word;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (fifo_count == FULL_CNT)));

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Host-side initiator for the 4-bit ALU tile. It accepts operand/opcode commands on a valid/ready stream and drives the ALU's registered operand/opcode interface at one command per cycle. It captures result, carry and overflow at the fixed ALU latency and returns tagged responses in order through a response FIFO with credit-based backpressure.

Parameters:
ALU_LAT, 1, clock edges from ALU input sampling to a valid ALU result (ALU registers its output once).
RSP_DEPTH, 4, response FIFO entries; also the cap on in-flight plus buffered responses (power of 2, at least 2).
TAG_W, 4, width of the command/response tag.
IDLE_OP, 4'b1111, opcode driven to the ALU when no command is issued (the ALU default case clears its outputs).

Ports:
clk  in  1  clock
rst_n  in  1  reset
cmd_valid  in  1  command valid
cmd_ready  out  1  command accepted when valid&ready at posedge
cmd_op  in  4  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 AND, 5 OR, 6 XOR, 7 NOT, 8 ENC, 9 SLT, A SEQ
cmd_a  in  4  operand a
cmd_b  in  4  operand b
cmd_tag  in  TAG_W  opaque tag, returned with the response
alu_ab  out  8  {a,b} to ALU, registered
alu_op  out  4  opcode to ALU, registered
alu_result  in  8  ALU result
alu_carry  in  1  ALU carry_out
alu_ovf  in  1  ALU overflow
rsp_valid  out  1  response valid (FIFO not empty)
rsp_ready  in  1  response consumed when valid&ready at posedge
rsp_result  out  8  captured result
rsp_carry  out  1  carry (ADD/SUB only, else 0)
rsp_ovf  out  1  overflow (ADD/SUB only, else 0)
rsp_err  out  1  illegal opcode (B..F)
rsp_tag  out  TAG_W  tag of this response
busy  out  1  any command in flight or buffered
issue_count  out  16  accepted commands, wraps at 0xFFFF->0

Behaviour:
- Reset is asynchronous and active-low on rst_n; the clock is clk. In reset, all outputs are 0 except alu_op=IDLE_OP and cmd_ready=1. The FIFO, pipeline and counter are cleared.
- Reset mid-operation drops all in-flight and buffered responses. There is no partial response afterwards.
- Credit rule: cmd_ready = (fifo_count + inflight) < RSP_DEPTH. It is combinational from registered state only and never depends on cmd_valid.
- Accept at edge k drives alu_ab={cmd_a,cmd_b} and alu_op=cmd_op from edge k.
- The ALU samples at edge k+1. The sequencer captures alu_result/carry/ovf at edge k+ALU_LAT+1, i.e. k+2 by default, into the FIFO.
- This path uses a shift pipeline of length ALU_LAT+1 carrying {valid, tag, op_is_addsub, err}.
- No accept at edge k: the sequencer drives alu_op=IDLE_OP and alu_ab=0.
- Throughput is 1 command/cycle. Back-to-back accepts produce back-to-back captures, and order is strictly preserved.
- Flags: the ALU holds carry/ovf across non-arithmetic ops. The sequencer therefore masks rsp_carry and rsp_ovf to 0 unless op is ADD or SUB.
- Illegal opcode (0xB-0xF) is accepted and not issued (alu_op=IDLE_OP). It traverses the pipeline with err=1, result=0, carry=0, ovf=0.
- FIFO: circular buffer with a (log2(RSP_DEPTH)+1)-bit count. Simultaneous push and pop is allowed, including when the FIFO is full, and leaves the count unchanged. Pointers wrap modulo RSP_DEPTH.
- Overflow of the FIFO is impossible by the credit rule. An assertion is required: push while full without pop is an error.
- Response outputs are driven from the FIFO head. They are stable while rsp_valid=1 and rsp_ready=0.
- busy = |pipeline_valid | (fifo_count != 0).
- issue_count increments on every accept, including illegal opcodes.

Test Plan:
- ADD a=9 b=8 -> rsp_result=0x01, carry=1, ovf=1, rsp_valid rises 2 cycles after accept plus one FIFO cycle; tag echoed.
- SUB a=3 b=5 -> result=0x0E, carry=0, ovf=0; MUL a=F b=F -> 0xE1, carry=0, ovf=0 (flags masked even though ALU holds prior values).
- DIV a=13 b=4 -> 0x13; DIV b=0 -> 0x00; ENC a=1 b=2 -> 0xB9; SLT a=2 b=7 -> 0x01.
- Back-to-back 8 commands with tags 0..7 and rsp_ready=1 -> 8 consecutive responses, tags in order, cmd_ready never drops.
- rsp_ready=0, 6 commands offered -> exactly 4 accepted, cmd_ready=0, busy=1. Raise rsp_ready -> remaining 2 accepted, 6 responses in order.
- cmd_op=0xC tag=5 -> alu_op stays IDLE_OP, response err=1, result=0. Assert rst_n with 3 in flight -> rsp_valid=0 next cycle, issue_count=0, cmd_ready=1.
